// File: rtl/mips_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mips_dmem_arbiter
//  Description : Two-port round-robin arbiter in front of a single-ported,
//                word-addressed MIPS data memory. Port 0 is the CPU and
//                port 1 is a DMA/debug master. Each accepted request is
//                served as one transaction. A write is IDLE -> ACCESS -> IDLE.
//                An in-range read is IDLE -> ACCESS -> RESP -> IDLE. An
//                out-of-range access is answered with a gnt+err pulse and
//                never reaches the memory.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W          data memory word-address width (default 8 = 256 words)
//  Ports
//    clk             rising-edge clock
//    rst             synchronous, active-high reset
//    pN_req          access request (N = 0 CPU, N = 1 DMA/debug)
//    pN_we           1 = write, 0 = read (qualified by pN_req)
//    pN_addr         32-bit word address
//    pN_wdata        32-bit write data
//    pN_gnt          one-cycle accept pulse
//    pN_err          one-cycle out-of-range pulse, coincident with pN_gnt
//    pN_rvalid       one-cycle read-data-valid pulse
//    pN_rdata        read data, held until the next pN_rvalid of that port
//    mem_address     memory word address (0 outside ACCESS)
//    write_data      memory write data (0 outside ACCESS)
//    sig_mem_read    memory read strobe
//    sig_mem_write   memory write strobe
//    read_data       memory read data, valid one cycle after sig_mem_read
//    busy            high whenever the FSM is not in IDLE
// ============================================================================
module mips_dmem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_err,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_err,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,

    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data,
    output logic        busy
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;

    // Round-robin pointer: the port that wins a tie in the next IDLE cycle.
    logic        r_ptr;

    // Latched transaction attributes, captured in the IDLE sample cycle.
    logic        r_win;
    logic        r_we;
    logic        r_oor;

    // Registered outputs, one bit per port where applicable.
    logic [1:0]  r_gnt;
    logic [1:0]  r_err;
    logic [1:0]  r_rvalid;
    logic [31:0] r_rdata [2];
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_busy;

    // ------------------------------------------------------------------
    // Request selection (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic [1:0]  w_req;
    logic        w_any_req;
    logic        w_win;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_in_range;

    assign w_req     = {p1_req, p0_req};
    assign w_any_req = |w_req;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        w_win = 1'b0;
        case (w_req)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = r_ptr;
            default: w_win = 1'b0;
        endcase
    end

    assign w_sel_we    = w_win ? p1_we    : p0_we;
    assign w_sel_addr  = w_win ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_win ? p1_wdata : p0_wdata;

    // Everything above the implemented word-address bits must be zero.
    // Shifting rather than slicing keeps this legal for any ADDR_W.
    assign w_in_range  = ((w_sel_addr >> ADDR_W) == 32'd0);

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    // Pulse outputs and the memory bus default to zero every cycle and are
    // only set on the edge that enters the cycle in which they must be seen.
    // The memory strobes are therefore launched on the IDLE->ACCESS edge,
    // which makes them visible exactly during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_win       <= 1'b0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_gnt       <= 2'b00;
            r_err       <= 2'b00;
            r_rvalid    <= 2'b00;
            r_rdata[0]  <= 32'd0;
            r_rdata[1]  <= 32'd0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt       <= 2'b00;
            r_err       <= 2'b00;
            r_rvalid    <= 2'b00;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ACCESS;
                        r_busy       <= 1'b1;
                        r_win        <= w_win;
                        r_we         <= w_sel_we;
                        r_oor        <= !w_in_range;
                        // Every grant, including an error grant, hands the
                        // tie-break to the other port.
                        r_ptr        <= !w_win;
                        r_gnt[w_win] <= 1'b1;
                        r_err[w_win] <= !w_in_range;
                        if (w_in_range) begin
                            r_mem_addr <= w_sel_addr;
                            if (w_sel_we) begin
                                r_mem_wr    <= 1'b1;
                                r_mem_wdata <= w_sel_wdata;
                            end else begin
                                r_mem_rd    <= 1'b1;
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (r_we || r_oor) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= RESP;
                    end
                end

                RESP: begin
                    // Memory data is valid now; only the winner's rdata
                    // register is touched so the other port keeps its value.
                    r_rdata[r_win]  <= read_data;
                    r_rvalid[r_win] <= 1'b1;
                    r_state         <= IDLE;
                    r_busy          <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign p0_gnt        = r_gnt[0];
    assign p0_err        = r_err[0];
    assign p0_rvalid     = r_rvalid[0];
    assign p0_rdata      = r_rdata[0];

    assign p1_gnt        = r_gnt[1];
    assign p1_err        = r_err[1];
    assign p1_rvalid     = r_rvalid[1];
    assign p1_rdata      = r_rdata[1];

    assign mem_address   = r_mem_addr;
    assign write_data    = r_mem_wdata;
    assign sig_mem_read  = r_mem_rd;
    assign sig_mem_write = r_mem_wr;
    assign busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mips_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_dmem_arbiter
//  Description : Self-checking bench for mips_dmem_arbiter. Directed
//                transactions push their expected gnt and rvalid events into
//                scoreboard queues, and a monitor on the falling clock edge
//                pops and compares each event the DUT presents. A
//                behavioural memory with one-cycle read latency serves the
//                memory side.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = 32'd0, p0_wdata = 32'd0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = 32'd0, p1_wdata = 32'd0;
    logic        p0_gnt, p0_err, p0_rvalid, p1_gnt, p1_err, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_address, write_data;
    logic        sig_mem_read, sig_mem_write, busy;
    logic [31:0] read_data = 32'd0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int          port;
        int          cyc;
        logic        err;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t gnt_q[$];
    exp_t rv_q[$];

    logic [31:0] mem [256];

    mips_dmem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_err(p0_err), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_err(p1_err), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .write_data(write_data),
        .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
        .read_data(read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: write on the strobe edge, read data one cycle later.
    always @(posedge clk) begin
        if (sig_mem_write) mem[mem_address[7:0]] <= write_data;
        if (sig_mem_read)  read_data <= mem[mem_address[7:0]];
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t        e;
        logic        ok;
        logic [31:0] got;
        if (sig_mem_read && sig_mem_write) begin
            n_checks++; n_errors++;
            $display("FAIL strobes_exclusive: both strobes high at cycle %0d", cyc);
        end
        if (p0_gnt || p1_gnt) begin
            n_checks++;
            if (gnt_q.size() == 0) begin
                n_errors++;
                $display("FAIL gnt_unexpected: gnt=%b%b at cycle %0d, none expected", p1_gnt, p0_gnt, cyc);
            end else begin
                e  = gnt_q.pop_front();
                ok = (p0_gnt == (e.port == 0)) && (p1_gnt == (e.port == 1)) && (cyc == e.cyc)
                  && (p0_err == ((e.port == 0) && e.err)) && (p1_err == ((e.port == 1) && e.err))
                  && (sig_mem_read == e.rd) && (sig_mem_write == e.wr)
                  && (mem_address == e.addr) && (write_data == e.data);
                if (!ok) begin
                    n_errors++;
                    $display("FAIL gnt_event: got gnt=%b%b err=%b%b rd=%b wr=%b addr=%h wdata=%h cyc=%0d; expected port=%0d err=%b rd=%b wr=%b addr=%h wdata=%h cyc=%0d",
                             p1_gnt, p0_gnt, p1_err, p0_err, sig_mem_read, sig_mem_write, mem_address, write_data, cyc,
                             e.port, e.err, e.rd, e.wr, e.addr, e.data, e.cyc);
                end
            end
        end else if (sig_mem_read || sig_mem_write || p0_err || p1_err
                     || mem_address != 32'd0 || write_data != 32'd0) begin
            n_checks++; n_errors++;
            $display("FAIL idle_bus: rd=%b wr=%b err=%b%b addr=%h wdata=%h at cycle %0d without gnt, expected all 0",
                     sig_mem_read, sig_mem_write, p1_err, p0_err, mem_address, write_data, cyc);
        end
        if (p0_rvalid || p1_rvalid) begin
            n_checks++;
            if (rv_q.size() == 0) begin
                n_errors++;
                $display("FAIL rvalid_unexpected: rvalid=%b%b at cycle %0d, none expected", p1_rvalid, p0_rvalid, cyc);
            end else begin
                e   = rv_q.pop_front();
                got = (e.port == 1) ? p1_rdata : p0_rdata;
                ok  = (p0_rvalid == (e.port == 0)) && (p1_rvalid == (e.port == 1))
                   && (cyc == e.cyc) && (got == e.data);
                if (!ok) begin
                    n_errors++;
                    $display("FAIL rvalid_event: got rvalid=%b%b rdata=%h cyc=%0d; expected port=%0d rdata=%h cyc=%0d",
                             p1_rvalid, p0_rvalid, got, cyc, e.port, e.data, e.cyc);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic exp_gnt(input int port, input int c, input logic err, input logic rd,
                           input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.port = port; e.cyc = c; e.err = err; e.rd = rd; e.wr = wr; e.addr = a; e.data = d;
        gnt_q.push_back(e);
    endtask

    task automatic exp_rv(input int port, input int c, input logic [31:0] d);
        exp_t e;
        e.port = port; e.cyc = c; e.err = 1'b0; e.rd = 1'b0; e.wr = 1'b0; e.addr = 32'd0; e.data = d;
        rv_q.push_back(e);
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One transaction from an idle arbiter; expected values built from the
    // operands alone (ADDR_W = 8: bits [31:8] must be zero).
    task automatic single(input int port, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd_exp);
        int   k;
        logic oor;
        k   = cyc;
        oor = (a[31:8] != 24'd0);
        exp_gnt(port, k + 1, oor, !oor && !we, !oor && we,
                oor ? 32'd0 : a, (!oor && we) ? wd : 32'd0);
        if (!oor && !we) exp_rv(port, k + 3, rd_exp);
        drive(port, 1'b1, we, a, wd);
        @(posedge clk); #1;
        check("busy_in_access", {31'd0, busy}, 32'd1);
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("busy_cycle2", {31'd0, busy}, {31'd0, (!oor && !we)});
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int k;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {23'd0, p0_gnt, p0_err, p0_rvalid, p1_gnt, p1_err, p1_rvalid,
                             sig_mem_read, sig_mem_write, busy}, 32'd0);
        check("reset_p0_rdata", p0_rdata, 32'd0);
        check("reset_p1_rdata", p1_rdata, 32'd0);
        check("reset_mem_address", mem_address, 32'd0);
        check("reset_write_data", write_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write, single read, top-of-range word.
        single(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'd0);
        single(1, 1'b0, 32'h0000_0005, 32'd0, 32'hDEAD_BEEF);
        single(1, 1'b1, 32'h0000_00FF, 32'h1234_5678, 32'd0);
        single(0, 1'b0, 32'h0000_00FF, 32'd0, 32'h1234_5678);
        check("p1_rdata_isolated", p1_rdata, 32'hDEAD_BEEF);

        // Out-of-range read and write.
        single(0, 1'b0, 32'h0000_0100, 32'd0, 32'd0);
        single(1, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 32'd0);
        check("p0_rdata_after_err", p0_rdata, 32'h1234_5678);

        // Continuous contention after reset: p0, p1, p0, p1.
        do_reset();
        k = cyc;
        exp_gnt(0, k + 1, 1'b0, 1'b0, 1'b1, 32'h10, 32'hA0A0_A0A0);
        exp_gnt(1, k + 3, 1'b0, 1'b0, 1'b1, 32'h11, 32'hB1B1_B1B1);
        exp_gnt(0, k + 5, 1'b0, 1'b0, 1'b1, 32'h10, 32'hA0A0_A0A0);
        exp_gnt(1, k + 7, 1'b0, 1'b0, 1'b1, 32'h11, 32'hB1B1_B1B1);
        drive(0, 1'b1, 1'b1, 32'h10, 32'hA0A0_A0A0);
        drive(1, 1'b1, 1'b1, 32'h11, 32'hB1B1_B1B1);
        repeat (7) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Read on p0 against a waiting write on p1; p1 served next IDLE.
        k = cyc;
        exp_gnt(0, k + 1, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        exp_rv(0, k + 3, 32'hA0A0_A0A0);
        exp_gnt(1, k + 4, 1'b0, 1'b0, 1'b1, 32'h12, 32'hC3C3_C3C3);
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b1, 32'h12, 32'hC3C3_C3C3);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        single(1, 1'b0, 32'h12, 32'd0, 32'hC3C3_C3C3);
        check("p0_rdata_isolated", p0_rdata, 32'hA0A0_A0A0);

        // Reset in the RESP cycle of a p0 read.
        k = cyc;
        exp_gnt(0, k + 1, 1'b0, 1'b1, 1'b0, 32'h05, 32'd0);
        drive(0, 1'b1, 1'b0, 32'h05, 32'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("busy_in_resp", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("busy_after_abort", {31'd0, busy}, 32'd0);
        check("p0_rvalid_after_abort", {31'd0, p0_rvalid}, 32'd0);
        check("p0_rdata_after_abort", p0_rdata, 32'd0);
        k = cyc;
        exp_gnt(0, k + 1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0000_0001);
        exp_gnt(1, k + 3, 1'b0, 1'b0, 1'b1, 32'h21, 32'h0000_0002);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h0000_0001);
        drive(1, 1'b1, 1'b1, 32'h21, 32'h0000_0002);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #1;

        check("gnt_queue_drained", gnt_q.size(), 32'd0);
        check("rvalid_queue_drained", rv_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mips_dmem_arbiter.md
MIPS_DMEM_ARBITER -- requirements
Module: mips_dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning data memory word-address width (256 words).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports pN_req  input  1  access request, N = 0 (CPU), 1 (DMA/debug).
REQ-005 The block SHALL have ports pN_we  input  1  1 = write, 0 = read, qualified by pN_req.
REQ-006 The block SHALL have ports pN_addr  input  32  word address.
REQ-007 The block SHALL have ports pN_wdata  input  32  write data.
REQ-008 The block SHALL have ports pN_gnt  output  1  one-cycle accept pulse.
REQ-009 The block SHALL have ports pN_err  output  1  one-cycle out-of-range pulse, coincident with pN_gnt.
REQ-010 The block SHALL have ports pN_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-011 The block SHALL have ports pN_rdata  output  32  read data, held until the next pN_rvalid.
REQ-012 The block SHALL have port mem_address  output  32  memory word address.
REQ-013 The block SHALL have port write_data  output  32  memory write data.
REQ-014 The block SHALL have port sig_mem_read  output  1  memory read strobe.
REQ-015 The block SHALL have port sig_mem_write  output  1  memory write strobe.
REQ-016 The block SHALL have port read_data  input  32  memory read data, valid one cycle after the sig_mem_read cycle.
REQ-017 The block SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, RESP; all outputs SHALL be registered.
REQ-019 In IDLE with at least one pN_req high, the block SHALL latch winner id, we, addr and wdata, and SHALL go to ACCESS; with no request it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: a priority pointer selects the winner when both ports request in the same IDLE cycle, and after each grant the pointer SHALL move to the other port.
REQ-021 A lone requester SHALL win regardless of the pointer.
REQ-022 In ACCESS, the block SHALL pulse pN_gnt of the winner for exactly one cycle.
REQ-023 In ACCESS with an in-range address, the block SHALL drive mem_address = latched addr and assert exactly one of sig_mem_write (we = 1, write_data = latched wdata) or sig_mem_read (we = 0).
REQ-024 An address is in range if and only if addr[31:ADDR_W] == 0; an out-of-range address SHALL pulse pN_err with pN_gnt, assert no memory strobe, and return the FSM to IDLE with no pN_rvalid.
REQ-025 From ACCESS, a write or an error SHALL go to IDLE, and an in-range read SHALL go to RESP.
REQ-026 In RESP, the block SHALL capture read_data into the winner's pN_rdata and pulse pN_rvalid in the following cycle, then go to IDLE.
REQ-027 Latency SHALL be: write = 2 cycles IDLE to IDLE; read = gnt at cycle 1 and rvalid at cycle 3, counting the IDLE sample cycle as 0.
REQ-028 A requester SHALL hold pN_req and operands stable until it sees pN_gnt, and SHALL drop pN_req in the cycle after pN_gnt; a request still high in IDLE SHALL be treated as a new request.
REQ-029 A losing requester SHALL wait, with its operands held, and SHALL be served at the next IDLE, so that no port waits more than one transaction of the other.
REQ-030 Outside ACCESS, sig_mem_read and sig_mem_write SHALL be 0, and mem_address and write_data SHALL be 0; the two strobes SHALL never be high together.
REQ-031 The rdata of a port SHALL be unaffected by transactions of the other port.

Reset
REQ-032 rst high at a clock edge SHALL force IDLE, clear the priority pointer to port 0, and set all gnt, err, rvalid, strobe and busy outputs to 0 and all pN_rdata, mem_address and write_data to 0.
REQ-033 Reset during ACCESS or RESP SHALL abort the transaction: no pN_rvalid SHALL follow, and a write strobe already issued is not retracted.
REQ-034 The first request after rst is deasserted SHALL be sampled in the next IDLE cycle.

Verification
REQ-035 Single write: p0 write addr 0x05 data 0xDEADBEEF -> p0_gnt and sig_mem_write high in cycle 1 with mem_address = 5; busy is 0 in cycle 2.
REQ-036 Single read: p1 read addr 0x05 with the memory returning 0xDEADBEEF -> p1_gnt in cycle 1, sig_mem_read in cycle 1, p1_rvalid with p1_rdata = 0xDEADBEEF in cycle 3.
REQ-037 Contention: p0 and p1 both request continuously after reset -> grants alternate p0, p1, p0, p1, and no grant is lost.
REQ-038 Out of range: p0 read addr 0x100 (ADDR_W = 8) -> p0_gnt and p0_err in cycle 1, no memory strobe, no p0_rvalid.
REQ-039 Reset mid-read: rst in the RESP cycle -> no p0_rvalid, busy = 0, and the next simultaneous requests are granted to p0 first.
